rr_arb_mux_4_1: RTL and testbench
=================================

Name: rr_arb_mux_4_1

Overview:
- 4-channel round-robin arbiter plus output register that drives the select of the team's 4-bit 4:1 mux (`mux_4_1`).
- Sits directly upstream of the mux select: it picks one of four valid/ready input channels and steers its data through `mux_4_1`.
- Registers the selected word toward a single valid/ready consumer.
- Provides fair, back-pressure-aware merging of four narrow streams into one.

Parameters:
- WIDTH, 4, data width per channel. `mux_4_1` is 4 bits wide, so data is split into 4-bit slices, one `mux_4_1` instance per slice. WIDTH must be a multiple of 4.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  4  per-channel valid, bit i = channel i
- in_data0  input  WIDTH  channel 0 data
- in_data1  input  WIDTH  channel 1 data
- in_data2  input  WIDTH  channel 2 data
- in_data3  input  WIDTH  channel 3 data
- in_ready  output  4  per-channel ready; one-hot or zero
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered selected data
- out_src  output  2  index of the channel that produced out_data
- out_ready  input  1  consumer accepts when high
- sel  output  2  combinational mux select = granted index this cycle (0 when no grant)

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, out_data=0, out_src=0, priority pointer ptr=0.
  - in_ready and sel follow combinationally from the reset state.
  - Reset mid-transfer drops any held word. No in-flight state survives.
- can_accept = !out_valid | out_ready.
- Grant search, combinational:
  - Starting at ptr, scan ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first i with in_valid[i]=1 is the winner g.
  - No valid channel means no grant and sel=0.
- Ready: in_ready[g]=can_accept; all other bits 0. in_ready must not depend on in_data.
- sel=g whenever any in_valid is set, regardless of can_accept. Data path: out_data_next = `mux_4_1`(in_data0..3, sel), per 4-bit slice.
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. On that edge:
  - out_data<=selected data, out_src<=g, out_valid<=1.
  - ptr<=(g+1) mod 4, with 2-bit wrap 3->0.
- Else if out_valid & out_ready: out_valid<=0. out_data and out_src hold their last values.
- Else: all registers hold. ptr advances only on a transfer, never on mere valid or stall.
- Simultaneous drain and fill in one cycle (out_valid=1, out_ready=1, grant present): new word loaded, out_valid stays 1. Gives full throughput of 1 word/cycle.
- Latency: input transfer at edge N, word visible on out_* after edge N.
- Stall (out_valid=1, out_ready=0):
  - in_ready=0, out_data and out_src stable.
  - sel may change as in_valid changes, because sel is not qualified by can_accept.
- Input rule: once in_valid[i] is raised it is held until transferred. The arbiter does not check this.
- Fairness: with all four channels continuously valid and out_ready=1, grants cycle 0,1,2,3,0,... Each channel waits at most 3 transfers.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, out_src=0. First grant after release is channel 0.
- Single channel: in_valid=4'b0100, in_data2=4'hA, out_ready=1 -> in_ready=4'b0100, sel=2; next cycle out_valid=1, out_data=4'hA, out_src=2, ptr=3.
- Round-robin: in_valid=4'b1111 with data 4'h1/4'h2/4'h3/4'h4, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3, out_data 1,2,3,4,1,2,3,4, out_valid continuously 1.
- Back-pressure: load a word (out_src=1, out_data=4'h5), then out_ready=0 for 3 cycles with in_valid=4'b1111 -> in_ready=0, out_* unchanged, ptr=2. After out_ready=1, next word is from channel 2.
- Wrap and skip: ptr=3, in_valid=4'b0010 -> grant channel 1 (wrap 3->0->1), ptr becomes 2. Then in_valid=4'b0001 -> grant channel 0.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst 1 cycle -> out_valid=0, ptr=0. Pending word is discarded.

Source files
------------

// File: rtl/rr_arb_mux_4_1.sv
// Four-channel round-robin arbiter feeding a registered output stage.
// The granted index drives the select of 4-bit mux_4_1 slices; the
// selected word is captured in a single-entry output register.
//
// Handshake: a word moves across an interface on a rising edge where
// valid and ready are both high; valid, once raised, is held until that
// edge, and ready never depends on the data of the same interface.

// 4-bit 4:1 multiplexer, one instance per 4-bit slice of the data path.
module mux_4_1 (
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [1:0] sel,
    output logic [3:0] y
);

    // Plain select decode.
    always_comb begin
        y = d0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

module rr_arb_mux_4_1 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready,
    output logic [1:0]       sel
);

    localparam int SLICES = WIDTH / 4;

    // Channel that gets first look in the next grant search.
    logic [1:0]       ptr;
    logic             grant_valid;
    logic [1:0]       grant_idx;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] mux_data;

    assign can_accept = !out_valid || out_ready;
    assign xfer       = grant_valid && can_accept;
    assign sel        = grant_idx;

    // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); first valid channel wins.
    always_comb begin
        logic [1:0] idx;
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        idx         = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!grant_valid && in_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Only the winner sees ready, and only when the output slot can take a word.
    always_comb begin
        in_ready = 4'b0000;
        if (grant_valid) begin
            in_ready[grant_idx] = can_accept;
        end
    end

    // Data path split into 4-bit slices, each steered by the grant.
    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        mux_4_1 u_mux (
            .d0  (in_data0[4*s +: 4]),
            .d1  (in_data1[4*s +: 4]),
            .d2  (in_data2[4*s +: 4]),
            .d3  (in_data3[4*s +: 4]),
            .sel (sel),
            .y   (mux_data[4*s +: 4])
        );
    end

    // Output register and priority pointer; a fill wins over a drain in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            ptr       <= 2'd0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_src   <= grant_idx;
            ptr       <= grant_idx + 2'd1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Bench for rr_arb_mux_4_1: directed scenarios followed by constrained
// random traffic, checked against a cycle model and an expected-word queue.
module tb_rr_arb_mux_4_1;

    localparam int W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   in_valid;
    logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_ready;
    logic [1:0]   sel;

    rr_arb_mux_4_1 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .sel       (sel)
    );

    // ---------------- scoreboard / model state ----------------
    logic [W+1:0] exp_q[$];        // {src, data} of words loaded, not yet drained
    int           n_checks = 0;
    int           n_errors = 0;
    logic [1:0]   m_ptr;
    logic         m_out_valid;
    logic [W-1:0] m_last_data;
    logic [1:0]   m_last_src;
    logic         m_xfer;
    logic [1:0]   m_xg;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] chan_data(input logic [1:0] i);
        case (i)
            2'd0:    return in_data0;
            2'd1:    return in_data1;
            2'd2:    return in_data2;
            default: return in_data3;
        endcase
    endfunction

    task automatic model_reset();
        m_ptr       = 2'd0;
        m_out_valid = 1'b0;
        m_last_data = '0;
        m_last_src  = 2'd0;
        exp_q.delete();
    endtask

    // One clock: check outputs at negedge, advance the model, move past posedge.
    task automatic cycle();
        logic       any;
        logic [1:0] g;
        logic       can;
        logic [3:0] exp_rdy;
        logic [W+1:0] front;
        @(negedge clk);
        any = 1'b0;
        g   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!any && in_valid[(int'(m_ptr) + k) % 4]) begin
                any = 1'b1;
                g   = 2'((int'(m_ptr) + k) % 4);
            end
        end
        can     = !m_out_valid || out_ready;
        exp_rdy = (any && can) ? (4'b0001 << g) : 4'b0000;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("sel", 32'(sel), 32'(g));
        check("ptr", 32'(dut.ptr), 32'(m_ptr));
        check("out_valid", 32'(out_valid), 32'(m_out_valid));
        if (m_out_valid) begin
            if (exp_q.size() == 0) begin
                check("queue_empty", 32'(1), 32'(0));
            end else begin
                front = exp_q[0];
                check("out_src", 32'(out_src), 32'(front[W+1:W]));
                check("out_data", 32'(out_data), 32'(front[W-1:0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end else begin
            check("out_src_hold", 32'(out_src), 32'(m_last_src));
            check("out_data_hold", 32'(out_data), 32'(m_last_data));
        end
        m_xfer = 1'b0;
        m_xg   = g;
        if (rst) begin
            model_reset();
        end else if (any && can) begin
            m_xfer      = 1'b1;
            m_last_data = chan_data(g);
            m_last_src  = g;
            exp_q.push_back({g, m_last_data});
            m_ptr       = g + 2'd1;
            m_out_valid = 1'b1;
        end else if (m_out_valid && out_ready) begin
            m_out_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic rdy, input int n);
        in_valid  = v;
        out_ready = rdy;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in_data0 = 4'h1; in_data1 = 4'h2; in_data2 = 4'h3; in_data3 = 4'h4;
        @(posedge clk); #1;
        model_reset();
        cycle();                          // second reset cycle, checks reset state
        check("rst_out_valid", 32'(out_valid), 32'(0));
        rst = 1'b0;

        // Round robin 0,1,2,3,0,1,2,3 then drain
        drive(4'b1111, 1'b1, 8);
        drive(4'b0000, 1'b1, 1);

        // Single channel 2
        in_data2 = 4'hA;
        drive(4'b0100, 1'b1, 1);
        check("single_out_data", 32'(out_data), 32'hA);
        check("single_ptr", 32'(dut.ptr), 32'd3);
        drive(4'b0000, 1'b1, 1);

        // Wrap 3->0->1, then channel 0
        drive(4'b0010, 1'b1, 1);
        check("wrap_src", 32'(out_src), 32'd1);
        drive(4'b0001, 1'b1, 1);
        check("wrap2_src", 32'(out_src), 32'd0);
        drive(4'b0000, 1'b1, 1);

        // Back-pressure: load word from channel 1, stall, release
        in_data1 = 4'h5;
        drive(4'b0010, 1'b1, 1);
        drive(4'b1111, 1'b0, 3);
        check("bp_data", 32'(out_data), 32'h5);
        check("bp_ptr", 32'(dut.ptr), 32'd2);
        drive(4'b1111, 1'b1, 1);
        check("bp_next_src", 32'(out_src), 32'd2);
        drive(4'b0000, 1'b1, 1);

        // Reset mid-stall discards held word
        drive(4'b0001, 1'b0, 2);
        rst = 1'b1;
        drive(4'b0000, 1'b0, 1);
        rst = 1'b0;
        drive(4'b0000, 1'b1, 1);
        check("rst_stall_valid", 32'(out_valid), 32'(0));

        // Random traffic with held valids
        in_valid = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            logic [3:0] v;
            v = in_valid;
            if (m_xfer) v[m_xg] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    v[i] = 1'b1;
                    case (i)
                        0: in_data0 = W'($urandom_range(0, 15));
                        1: in_data1 = W'($urandom_range(0, 15));
                        2: in_data2 = W'($urandom_range(0, 15));
                        default: in_data3 = W'($urandom_range(0, 15));
                    endcase
                end
            end
            drive(v, ($urandom_range(0, 3) != 0), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
